core_launcher: RTL and testbench
================================

# core_launcher

Boot and run sequencer that sits directly upstream of the processor top level. It streams a program into instruction memory over a valid/ready handshake and holds the core in reset (`start` high) while it loads. It then releases the core, counts execution cycles until the core raises `done`, and reports the cycle count, timeout and load-error status to the test harness or host.

## Interface
Parameters:
- D, 12, instruction address / program counter width
- W, 9, machine-code word width
- C, 16, cycle counter width

Ports:
- clk  in  1  system clock
- start  in  1  reset; synchronous, active-high
- go  in  1  request a load-and-run; sampled only in IDLE
- ld_valid  in  1  program word available
- ld_ready  out  1  launcher accepts a word this cycle
- ld_data  in  W  machine-code word
- ld_last  in  1  qualifies the final word of the program
- im_wr_en  out  1  instruction memory write strobe
- im_wr_addr  out  D  instruction memory write address
- im_wr_data  out  W  instruction memory write data
- core_start  out  1  drives the core's `start` (reset) input
- core_done  in  1  core's `done` output
- max_cycles  in  C  timeout limit; sampled on `go` acceptance
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle completion pulse
- timed_out  out  1  sticky; the run hit `max_cycles`
- load_err  out  1  sticky; the program exceeded 2^D words
- cycles  out  C  RUN cycles counted; held until the next `go`

## Operation
The block is a five-state FSM: IDLE, LOAD, FLUSH, RUN, REPORT.

- **IDLE**
  - `ld_ready`=0 and `core_start`=1.
  - On `go`=1: clear `timed_out`, `load_err` and `cycles`; latch `max_cycles`; reset the write pointer to 0; go to LOAD.
- **LOAD**
  - `ld_ready`=1 and `core_start`=1.
  - Each accept (`ld_valid` & `ld_ready`) registers a write at the pointer, then increments the pointer.
  - Accept with `ld_last`=1: go to FLUSH.
  - Accept at pointer 2^D-1 with `ld_last`=0: the write still occurs, `load_err` is set, and the FSM returns to IDLE. No run follows.
- **FLUSH**
  - Lasts one cycle; lets the last registered write land.
  - `core_start`=1 and `ld_ready`=0. Go to RUN.
- **RUN**
  - `core_start`=0.
  - If `core_done`=1: go to REPORT with `cycles` unchanged.
  - Else if `cycles`==`max_cycles`: set `timed_out` and go to REPORT.
  - Else: `cycles`++.
  - If done and the limit coincide in the same cycle, done wins and `timed_out` stays 0.
- **REPORT**
  - `run_done`=1 for exactly one cycle.
  - `core_start` returns to 1. Go to IDLE.

Boundary rules:
- `core_done` is ignored outside RUN.
- `go` is ignored while `busy`.
- `ld_data` and `ld_last` are don't-care unless `ld_valid`=1.
- `max_cycles`=0 with no done on the first RUN cycle gives a timeout with `cycles`=0.
- `cycles` never wraps, because the limit check precedes the increment.

## Timing
- All outputs are registered except `ld_ready` and `busy`, which decode directly from state.
- Reset values:
  - `core_start`=1
  - `ld_ready`=0, `im_wr_en`=0, `im_wr_addr`=0, `im_wr_data`=0
  - `busy`=0, `run_done`=0, `timed_out`=0, `load_err`=0
  - `cycles`=0
  - state IDLE
- `start` asserted in any state forces the reset values on the next edge and drops any pending write. The core is therefore held in reset.
- Write latency: a word accepted at edge n appears on `im_wr_*` during cycle n+1.
- `go` to first accept opportunity: 1 cycle.
- Last accept to `core_start` falling: 2 edges (FLUSH in between).
- `core_start` was high for at least 2 cycles before RUN, so the core PC is 0 in the first RUN cycle.
- `core_done` seen in RUN cycle k (k=0 is the first) gives `cycles`=k, and `run_done` pulses in cycle k+1.

## Structure
- `launcher_pkg` contains:
  - the state enum `launch_state_t` (IDLE, LOAD, FLUSH, RUN, REPORT)
  - the default widths D=12, W=9, C=16
- One sub-module, `run_timer`:
  - inputs: clear, enable, limit latch
  - outputs: `cycles`, `hit_limit`
- FSM, write pointer and handshake logic stay in `core_launcher`.

## Test plan
- **Load and run:** load 3 words (0x1A0, 0x0C3, 0x1FF, `ld_last` on the third) with `ld_valid` held high.
  - Writes at addresses 0,1,2 on consecutive cycles with matching data.
  - `core_start` falls 2 cycles after the third accept.
  - `core_done` asserted in RUN cycle 138 gives `cycles`=138, `run_done` one-cycle pulse, `timed_out`=0.
- **Backpressure gaps:** `ld_valid` toggles 1,0,0,1,1 with `ld_last` on the third valid word.
  - Exactly 3 writes, at addresses 0-2.
  - No write in the gap cycles.
- **Timeout:** `max_cycles`=5 with `core_done` never asserted.
  - `timed_out`=1, `cycles`=5, `run_done` pulses.
  - `core_start`=1 afterwards.
- **Simultaneous events:** `max_cycles`=4 and `core_done` asserted in RUN cycle 4.
  - `timed_out`=0, `cycles`=4.
  - Separately, `max_cycles`=0 with no done gives a timeout with `cycles`=0.
- **Overflow:** with D=4, stream 16 words without `ld_last`.
  - 16 writes (addresses 0-15), then `load_err`=1.
  - Return to IDLE with `core_start` never falling.
  - `load_err` clears on the next `go` accept.
- **Reset mid-operation:** assert `start` in RUN cycle 10, then in LOAD after 2 accepts.
  - Next cycle: all outputs at reset values, no `im_wr_en`, and `go` is honoured on the following cycle.

Source files
------------

// File: rtl/launcher_pkg.sv
// Shared definitions for the core launcher: FSM state encoding and the
// default widths used by the top level and its run timer.
package launcher_pkg;

    // Instruction address / PC width, machine-code word width, cycle counter width
    localparam int DEF_D = 12;
    localparam int DEF_W = 9;
    localparam int DEF_C = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4
    } launch_state_t;

endpackage

// File: rtl/core_launcher_run_timer.sv
// run_timer: execution cycle counter with a latched limit.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clear      zero the counter (takes priority over enable)
//   enable     advance the counter by one
//   load_limit capture limit_in as the comparison limit
//   limit_in   timeout limit to capture
//   cycles     current count
//   hit_limit  count equals the latched limit (combinational)
module run_timer
    import launcher_pkg::*;
#(
    parameter int C = DEF_C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         load_limit,
    input  logic [C-1:0] limit_in,
    output logic [C-1:0] cycles,
    output logic         hit_limit
);

    logic [C-1:0] limit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles  <= '0;
            limit_q <= '0;
        end else begin
            if (load_limit) begin
                limit_q <= limit_in;
            end
            if (clear) begin
                cycles <= '0;
            end else if (enable) begin
                cycles <= cycles + C'(1);
            end
        end
    end

    // The owner only enables counting when this is low, so the count can
    // never run past the limit and never wraps.
    assign hit_limit = (cycles == limit_q);

endmodule

// File: rtl/core_launcher.sv
// core_launcher: boot-and-run sequencer in front of the processor.
// Streams a program into instruction memory, holds the core in reset while
// loading, then releases it and times the run until the core signals done.
//
// Ports:
//   clk, start       clock; synchronous active-high reset
//   go               request a load-and-run (honoured only when idle)
//   ld_valid/ready   program word handshake; ld_data word, ld_last final word
//   im_wr_en/addr/data  registered instruction memory write port
//   core_start       core reset, low only while the core runs
//   core_done        core completion flag, observed only while running
//   max_cycles       timeout limit, captured when go is accepted
//   busy             not idle
//   run_done         one-cycle completion pulse
//   timed_out        sticky: the run reached max_cycles
//   load_err         sticky: program longer than 2^D words
//   cycles           cycles counted in the run, held until the next go
module core_launcher
    import launcher_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int W = DEF_W,
    parameter int C = DEF_C
) (
    input  logic         clk,
    input  logic         start,
    input  logic         go,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [W-1:0] ld_data,
    input  logic         ld_last,
    output logic         im_wr_en,
    output logic [D-1:0] im_wr_addr,
    output logic [W-1:0] im_wr_data,
    output logic         core_start,
    input  logic         core_done,
    input  logic [C-1:0] max_cycles,
    output logic         busy,
    output logic         run_done,
    output logic         timed_out,
    output logic         load_err,
    output logic [C-1:0] cycles
);

    launch_state_t state, next_state;
    logic [D-1:0]  wr_ptr;

    logic go_accept;
    logic accept;
    logic last_slot;
    logic timer_en;
    logic set_timeout;
    logic set_load_err;
    logic hit_limit;

    assign ld_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign go_accept = (state == IDLE) && go;
    assign accept    = ld_valid && ld_ready;
    assign last_slot = (wr_ptr == {D{1'b1}});

    run_timer #(
        .C(C)
    ) u_run_timer (
        .clk        (clk),
        .rst        (start),
        .clear      (go_accept),
        .enable     (timer_en),
        .load_limit (go_accept),
        .limit_in   (max_cycles),
        .cycles     (cycles),
        .hit_limit  (hit_limit)
    );

    always_comb begin
        next_state   = state;
        timer_en     = 1'b0;
        set_timeout  = 1'b0;
        set_load_err = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (ld_last) begin
                        next_state = FLUSH;
                    end else if (last_slot) begin
                        // Memory full and still no last word: abandon the run.
                        next_state   = IDLE;
                        set_load_err = 1'b1;
                    end
                end
            end
            FLUSH: begin
                next_state = RUN;
            end
            RUN: begin
                // done is checked first so a coincident limit is not a timeout
                if (core_done) begin
                    next_state = REPORT;
                end else if (hit_limit) begin
                    next_state  = REPORT;
                    set_timeout = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            REPORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            core_start <= 1'b1;
            run_done   <= 1'b0;
            timed_out  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state <= next_state;
            // Registered from next_state so core_start and run_done line up
            // exactly with the RUN and REPORT states.
            core_start <= (next_state != RUN);
            run_done   <= (next_state == REPORT);

            im_wr_en <= accept;
            if (accept) begin
                im_wr_addr <= wr_ptr;
                im_wr_data <= ld_data;
                wr_ptr     <= wr_ptr + D'(1);
            end

            if (go_accept) begin
                wr_ptr    <= '0;
                timed_out <= 1'b0;
                load_err  <= 1'b0;
            end
            if (set_timeout) begin
                timed_out <= 1'b1;
            end
            if (set_load_err) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_launcher.sv
module tb_core_launcher;

    localparam int D  = 12;
    localparam int W  = 9;
    localparam int C  = 16;
    localparam int D4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-width instance
    logic         start, go, ld_valid, ld_last, core_done;
    logic [W-1:0] ld_data;
    logic [C-1:0] max_cycles;
    logic         ld_ready, im_wr_en, core_start, busy, run_done, timed_out, load_err;
    logic [D-1:0] im_wr_addr;
    logic [W-1:0] im_wr_data;
    logic [C-1:0] cycles;

    // Narrow-address instance for overflow
    logic          start4, go4, ld_valid4, ld_last4, core_done4;
    logic [W-1:0]  ld_data4;
    logic [C-1:0]  max_cycles4;
    logic          ld_ready4, im_wr_en4, core_start4, busy4, run_done4, timed_out4, load_err4;
    logic [D4-1:0] im_wr_addr4;
    logic [W-1:0]  im_wr_data4;
    logic [C-1:0]  cycles4;

    core_launcher #(.D(D), .W(W), .C(C)) dut (
        .clk(clk), .start(start), .go(go), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .core_start(core_start), .core_done(core_done),
        .max_cycles(max_cycles), .busy(busy), .run_done(run_done), .timed_out(timed_out),
        .load_err(load_err), .cycles(cycles)
    );

    core_launcher #(.D(D4), .W(W), .C(C)) dut4 (
        .clk(clk), .start(start4), .go(go4), .ld_valid(ld_valid4), .ld_ready(ld_ready4),
        .ld_data(ld_data4), .ld_last(ld_last4), .im_wr_en(im_wr_en4), .im_wr_addr(im_wr_addr4),
        .im_wr_data(im_wr_data4), .core_start(core_start4), .core_done(core_done4),
        .max_cycles(max_cycles4), .busy(busy4), .run_done(run_done4), .timed_out(timed_out4),
        .load_err(load_err4), .cycles(cycles4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    wr_t w4q[$];
    wr_t mon_w;
    wr_t mon_w4;

    // Record every memory write with the cycle it was visible in
    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            mon_w.addr = int'(im_wr_addr);
            mon_w.data = int'(im_wr_data);
            mon_w.cyc  = cyc;
            wq.push_back(mon_w);
        end
        if (im_wr_en4 === 1'b1) begin
            mon_w4.addr = int'(im_wr_addr4);
            mon_w4.data = int'(im_wr_data4);
            mon_w4.cyc  = cyc;
            w4q.push_back(mon_w4);
        end
    end

    // Program and load-pattern description shared by the run scenarios
    logic [W-1:0] prog[0:31];
    int           acc_cyc[0:31];
    int           n_prog;
    int           gap_mode;   // 0: valid every cycle, 1: vpat, 2: random gaps
    bit           vpat[0:15];

    localparam logic [44:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 12'd0, 9'd0, 4'd0, 16'd0};

    // Complete load-and-run; expectations come from the run rules:
    // done at RUN cycle k (k <= limit) reports k, otherwise the limit times out.
    task automatic run_case(input int mx, input int done_k, input string tag);
        int  k, idx, pi, exp_cyc, exp_to;
        bit  seen, v;
        if (done_k >= 0 && done_k <= mx) begin
            exp_cyc = done_k;
            exp_to  = 0;
        end else begin
            exp_cyc = mx;
            exp_to  = 1;
        end
        wq.delete();
        @(negedge clk);
        go = 1'b1;
        max_cycles = C'(mx);
        @(negedge clk);
        go = 1'b0;
        n_checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b1 || core_start !== 1'b1)
            $display("FAIL %s load_entry: ready=%b busy=%b core_start=%b want 1 1 1", tag, ld_ready, busy, core_start);
        else n_pass++;
        idx = 0;
        pi  = 0;
        while (idx < n_prog && pi < 200) begin
            if (gap_mode == 0)      v = 1'b1;
            else if (gap_mode == 1) v = vpat[pi];
            else                    v = ($urandom_range(0, 2) != 0);
            ld_valid  = v;
            core_done = 1'($urandom_range(0, 1));
            go        = 1'($urandom_range(0, 1));
            if (v) begin
                ld_data = prog[idx];
                ld_last = (idx == n_prog - 1);
                acc_cyc[idx] = cyc;
                idx++;
            end else begin
                ld_data = W'($urandom);
                ld_last = 1'($urandom_range(0, 1));
            end
            pi++;
            @(negedge clk);
        end
        // FLUSH cycle
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        go        = 1'b0;
        core_done = 1'($urandom_range(0, 1));
        n_checks++;
        if (core_start !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s flush: core_start=%b ready=%b busy=%b want 1 0 1", tag, core_start, ld_ready, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (core_start !== 1'b0)
            $display("FAIL %s core_start_fall: got %b want 0", tag, core_start);
        else n_pass++;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < mx + 10) begin
            core_done = (k == done_k);
            go        = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
            if (run_done === 1'b1) seen = 1'b1;
        end
        core_done = 1'b0;
        go        = 1'b0;
        n_checks++;
        if (!seen || k != exp_cyc + 1)
            $display("FAIL %s run_done_timing: seen=%b at run cycle %0d want %0d", tag, seen, k, exp_cyc + 1);
        else n_pass++;
        n_checks++;
        if (cycles !== C'(exp_cyc) || timed_out !== 1'(exp_to) || load_err !== 1'b0)
            $display("FAIL %s result: cycles=%0d timed_out=%b load_err=%b want %0d %0d 0", tag, cycles, timed_out, load_err, exp_cyc, exp_to);
        else n_pass++;
        n_checks++;
        if (core_start !== 1'b1)
            $display("FAIL %s report_core_start: got %b want 1", tag, core_start);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (run_done !== 1'b0 || busy !== 1'b0 || core_start !== 1'b1 || cycles !== C'(exp_cyc) || timed_out !== 1'(exp_to))
            $display("FAIL %s after_report: run_done=%b busy=%b core_start=%b cycles=%0d to=%b want 0 0 1 %0d %0d",
                     tag, run_done, busy, core_start, cycles, timed_out, exp_cyc, exp_to);
        else n_pass++;
        n_checks++;
        if (wq.size() != n_prog)
            $display("FAIL %s write_count: got %0d want %0d", tag, wq.size(), n_prog);
        else n_pass++;
        for (int i = 0; i < n_prog && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].addr != i || wq[i].data != int'(prog[i]) || wq[i].cyc != acc_cyc[i] + 1)
                $display("FAIL %s write[%0d]: addr=%0d data=%h cyc=%0d want %0d %h %0d",
                         tag, i, wq[i].addr, wq[i].data, wq[i].cyc, i, prog[i], acc_cyc[i] + 1);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        start = 1'b1;
        go = 1'b1;
        ld_valid = 1'b1;
        core_done = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles} !== RESET_VEC)
            $display("FAIL reset_values: got %h want %h",
                     {core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles}, RESET_VEC);
        else n_pass++;
        n_checks++;
        if ({core_start4, ld_ready4, im_wr_en4, busy4, run_done4, timed_out4, load_err4} !== 7'b1000000)
            $display("FAIL reset_values_d4: got %b want 1000000",
                     {core_start4, ld_ready4, im_wr_en4, busy4, run_done4, timed_out4, load_err4});
        else n_pass++;
        start = 1'b0;
        go = 1'b0;
        ld_valid = 1'b0;
        core_done = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_and_run();
        prog[0] = 9'h1A0;
        prog[1] = 9'h0C3;
        prog[2] = 9'h1FF;
        n_prog = 3;
        gap_mode = 0;
        run_case(1000, 138, "load_and_run");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) prog[i] = W'($urandom);
        n_prog = 3;
        gap_mode = 1;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1;
        run_case(20, 7, "backpressure");
    endtask

    task automatic test_timeout();
        prog[0] = W'($urandom);
        prog[1] = W'($urandom);
        n_prog = 2;
        gap_mode = 0;
        run_case(5, -1, "timeout");
    endtask

    task automatic test_simultaneous();
        prog[0] = W'($urandom);
        n_prog = 1;
        gap_mode = 0;
        run_case(4, 4, "done_at_limit");
        run_case(0, -1, "zero_limit");
        run_case(0, 0, "zero_limit_done");
    endtask

    task automatic test_random();
        int mx, dk;
        for (int it = 0; it < 6; it++) begin
            n_prog = $urandom_range(1, 10);
            for (int i = 0; i < n_prog; i++) prog[i] = W'($urandom);
            gap_mode = 2;
            mx = $urandom_range(0, 60);
            dk = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, mx + 3));
            run_case(mx, dk, "random");
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] words[0:15];
        w4q.delete();
        @(negedge clk);
        go4 = 1'b1;
        max_cycles4 = 16'd5;
        @(negedge clk);
        go4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (core_start4 !== 1'b1 || ld_ready4 !== 1'b1)
                $display("FAIL ovf_loading[%0d]: core_start=%b ready=%b want 1 1", i, core_start4, ld_ready4);
            else n_pass++;
            words[i]  = W'($urandom);
            ld_valid4 = 1'b1;
            ld_data4  = words[i];
            ld_last4  = 1'b0;
            @(negedge clk);
        end
        ld_valid4 = 1'b0;
        n_checks++;
        if (load_err4 !== 1'b1 || busy4 !== 1'b0 || ld_ready4 !== 1'b0)
            $display("FAIL ovf_abort: load_err=%b busy=%b ready=%b want 1 0 0", load_err4, busy4, ld_ready4);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (core_start4 !== 1'b1 || busy4 !== 1'b0 || load_err4 !== 1'b1 || run_done4 !== 1'b0)
                $display("FAIL ovf_idle[%0d]: core_start=%b busy=%b load_err=%b run_done=%b want 1 0 1 0",
                         i, core_start4, busy4, load_err4, run_done4);
            else n_pass++;
        end
        n_checks++;
        if (w4q.size() != 16)
            $display("FAIL ovf_write_count: got %0d want 16", w4q.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < w4q.size(); i++) begin
            n_checks++;
            if (w4q[i].addr != i || w4q[i].data != int'(words[i]))
                $display("FAIL ovf_write[%0d]: addr=%0d data=%h want %0d %h", i, w4q[i].addr, w4q[i].data, i, words[i]);
            else n_pass++;
        end
        go4 = 1'b1;
        @(negedge clk);
        go4 = 1'b0;
        n_checks++;
        if (load_err4 !== 1'b0 || busy4 !== 1'b1)
            $display("FAIL ovf_clear_on_go: load_err=%b busy=%b want 0 1", load_err4, busy4);
        else n_pass++;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Reset during RUN cycle 10
        @(negedge clk);
        go = 1'b1;
        max_cycles = 16'd1000;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'($urandom);
            ld_last  = (i == 1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) @(negedge clk);
        n_checks++;
        if (core_start !== 1'b0 || cycles !== 16'd10)
            $display("FAIL mid_run_state: core_start=%b cycles=%0d want 0 10", core_start, cycles);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles} !== RESET_VEC)
            $display("FAIL reset_in_run: got %h want %h",
                     {core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles}, RESET_VEC);
        else n_pass++;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ld_ready !== 1'b1)
            $display("FAIL go_after_run_reset: busy=%b ready=%b want 1 1", busy, ld_ready);
        else n_pass++;
        // Reset in LOAD after two accepts, with a third word on offer
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'($urandom);
            ld_last  = 1'b0;
            @(negedge clk);
        end
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = W'($urandom);
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b0;
        n_checks++;
        if ({core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles} !== RESET_VEC)
            $display("FAIL reset_in_load: got %h want %h",
                     {core_start, ld_ready, im_wr_en, im_wr_addr, im_wr_data, busy, run_done, timed_out, load_err, cycles}, RESET_VEC);
        else n_pass++;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ld_ready !== 1'b1)
            $display("FAIL go_after_load_reset: busy=%b ready=%b want 1 1", busy, ld_ready);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; core_done = 1'b0;
        ld_data = '0; max_cycles = '0;
        start4 = 1'b1; go4 = 1'b0; ld_valid4 = 1'b0; ld_last4 = 1'b0; core_done4 = 1'b0;
        ld_data4 = '0; max_cycles4 = '0;
        n_prog = 0;
        gap_mode = 0;
        test_reset();
        test_load_and_run();
        test_backpressure();
        test_timeout();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
